// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, handshakes with instruction memory,
// holds each instruction until retired and picks the next PC from jump/branch outcome.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [5:0]       op_code,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             instr_done,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [31:0] PcInit = {PC_RESET[31:2], 2'b00};

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_inc;
  logic [31:0]      branch_off;
  logic [31:0]      next_pc;

  assign pc_inc     = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = {pc_inc[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_inc + branch_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_done) begin
          pc_d    = next_pc;
          state_d = StFetch;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= PcInit;
      instr_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign op_code     = instr_q[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against an architectural PC model.
module tb_instr_fetch_unit;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [5:0]      op_code;
  logic [31:0]     pc;
  logic [31:0]     pc_plus4;
  logic            instr_done;
  logic            jump;
  logic            branch;
  logic            zero;
  logic [CntW-1:0] retired_cnt;

  int checks   = 0;
  int failures = 0;

  // Architectural state of the reference model.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  int          exp_cnt;

  instr_fetch_unit #(
    .PC_RESET(32'h0000_0000),
    .CNT_W   (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .op_code    (op_code),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_done (instr_done),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MIPS next-PC rule computed with plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    longint unsigned p4;
    longint signed   imm;
    p4 = (longint'(cur) + 4) % 64'h1_0000_0000;
    if (j) return (p4 & 64'hF000_0000) | (longint'(ins & 32'h03FF_FFFF) * 4);
    if (b && z) begin
      imm = longint'(ins[15:0]);
      if (imm >= 32768) imm = imm - 65536;
      return 32'((longint'(p4) + imm * 4) & 64'hFFFF_FFFF);
    end
    return 32'(p4);
  endfunction

  // Starts in FETCH; waits `delay` cycles before acking with `word`.
  task automatic fetch(input logic [31:0] word, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("req_wait", {31'b0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
      step();
    end
    chk("req", {31'b0, imem_req}, 32'd1);
    chk("addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack  = 1'b0;
    exp_instr = word;
    chk("valid", {31'b0, instr_valid}, 32'd1);
    chk("req_drop", {31'b0, imem_req}, 32'd0);
    chk("instr", instr, word);
    chk("op_code", {26'b0, op_code}, {26'b0, word[31:26]});
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  // Starts in HOLD; idles `hold` cycles (optionally with a stray ack), then retires.
  task automatic retire(input logic j, input logic b, input logic z, input int hold,
                        input logic stray);
    for (int i = 0; i < hold; i++) begin
      imem_ack   = stray;
      imem_rdata = ~exp_instr;
      jump       = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", instr, exp_instr);
      chk("hold_pc", pc, exp_pc);
    end
    instr_done = 1'b1;
    jump       = j;
    branch     = b;
    zero       = z;
    step();
    instr_done = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    exp_pc     = model_next(exp_pc, exp_instr, j, b, z);
    if (exp_cnt < 15) exp_cnt++;
    chk("post_valid", {31'b0, instr_valid}, 32'd0);
    chk("post_req", {31'b0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, exp_pc);
    chk("cnt", {28'b0, retired_cnt}, 32'(exp_cnt));
  endtask

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    instr_done = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    exp_pc     = 32'h0;
    exp_instr  = 32'h0;
    exp_cnt    = 0;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_op", {26'b0, op_code}, 32'h0);
    chk("rst_cnt", {28'b0, retired_cnt}, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    step();

    // Basic fetch, ack one cycle late, sequential successor.
    fetch(32'h2008_0005, 1);
    chk("t1_op", {26'b0, op_code}, 32'h08);
    retire(1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("t1_next", imem_addr, 32'h4);

    // Jump to 0x40, then a jump at 0x40 back onto itself.
    fetch(32'h0800_0010, 0);
    retire(1'b1, 1'b0, 1'b0, 0, 1'b0);
    fetch(32'h0800_0010, 0);
    retire(1'b1, 1'b0, 1'b0, 1, 1'b0);
    chk("t2_jump", imem_addr, 32'h40);

    // Backward beq from 0x100 taken, then not taken.
    fetch(32'h0800_0040, 0);
    retire(1'b1, 1'b0, 1'b0, 0, 1'b0);
    fetch(32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk("t3_taken", imem_addr, 32'hFC);
    fetch(32'h0800_0040, 0);
    retire(1'b1, 1'b0, 1'b0, 0, 1'b0);
    fetch(32'h1000_FFFE, 2);
    retire(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_not_taken", imem_addr, 32'h104);

    // Jump beats a taken branch.
    fetch(32'h0800_0020, 0);
    retire(1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("t4_jump_wins", imem_addr, 32'h80);

    // Wrap below zero to 0xFFFF_FFFC, slow ack there, stray acks in HOLD, wrap back to 0.
    fetch(32'h0800_0000, 0);
    retire(1'b1, 1'b0, 1'b0, 0, 1'b0);
    fetch(32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk("t5_wrap_down", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0020, 5);
    retire(1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("t5_wrap_up", imem_addr, 32'h0);

    // Random traffic; also drives the 4-bit counter into saturation.
    for (int n = 0; n < 10; n++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    chk("cnt_sat", {28'b0, retired_cnt}, 32'hF);

    // Reset mid-FETCH with ack pending; late ack in IDLE must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    #1;
    chk("r6_req", {31'b0, imem_req}, 32'd0);
    chk("r6_valid", {31'b0, instr_valid}, 32'd0);
    chk("r6_cnt", {28'b0, retired_cnt}, 32'h0);
    chk("r6_addr", imem_addr, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("r6_late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("r6_late_ack_instr", instr, 32'h0);
    chk("r6_restart_req", {31'b0, imem_req}, 32'd1);
    imem_ack  = 1'b0;
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    exp_cnt   = 0;
    fetch(32'h2008_0005, 0);
    retire(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset mid-HOLD drops the held instruction.
    fetch(32'h1234_5678, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("rh_valid", {31'b0, instr_valid}, 32'd0);
    chk("rh_instr", instr, 32'h0);
    chk("rh_pc", pc, 32'h0);
    chk("rh_cnt", {28'b0, retired_cnt}, 32'h0);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
